// File: rtl/dct_pkg.sv
// Shared defaults and state encoding for the DCT processing-element MAC.
package dct_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int ACC_WIDTH_DEF  = 40;
    localparam int FRAC_BITS_DEF  = 14;
    localparam int OUT_WIDTH_DEF  = 16;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

endpackage

// File: rtl/dct_round_sat.sv
// Round-half-up fixed-point scaling of the accumulator, then clamp to the signed output range.
module dct_round_sat
    import dct_pkg::*;
#(
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int FRAC_BITS = FRAC_BITS_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
    input  logic signed [ACC_WIDTH-1:0] acc,
    output logic signed [OUT_WIDTH-1:0] value,
    output logic                        sat
);

    // One guard bit so the rounding bias cannot wrap a near-full-scale accumulator.
    localparam int W = ACC_WIDTH + 1;

    logic signed [W-1:0] ext;
    logic signed [W-1:0] biased;
    logic signed [W-1:0] shifted;
    logic signed [W-1:0] max_v;
    logic signed [W-1:0] min_v;

    assign ext = {acc[ACC_WIDTH-1], acc};

    generate
        if (FRAC_BITS > 0) begin : g_round
            assign biased = ext + (W'(1) << (FRAC_BITS - 1));
        end else begin : g_no_round
            assign biased = ext;
        end
    endgenerate

    assign shifted = biased >>> FRAC_BITS;
    assign max_v   = {{(W - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    assign min_v   = {{(W - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    always_comb begin
        sat   = 1'b0;
        value = shifted[OUT_WIDTH-1:0];
        if (shifted > max_v) begin
            value = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
            sat   = 1'b1;
        end else if (shifted < min_v) begin
            value = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
            sat   = 1'b1;
        end
    end

endmodule

// File: rtl/dct_pe_mac.sv
// Systolic DCT processing element: forwards operands south/east and accumulates a
// fixed-point dot product, emitting a rounded, saturated result with a valid/ready hold.
//
//   state | meaning
//   IDLE  | no open sum; next fire loads the accumulator
//   ACC   | sum open; fires add to the accumulator
module dct_pe_mac
    import dct_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int FRAC_BITS  = FRAC_BITS_DEF,
    parameter int OUT_WIDTH  = OUT_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] in_north,
    input  logic signed [DATA_WIDTH-1:0] in_west,
    input  logic                         north_valid,
    input  logic                         west_valid,
    input  logic                         acc_first,
    input  logic                         acc_last,
    output logic signed [DATA_WIDTH-1:0] out_south,
    output logic signed [DATA_WIDTH-1:0] out_east,
    output logic                         out_south_valid,
    output logic                         out_east_valid,
    output logic signed [OUT_WIDTH-1:0]  result,
    output logic                         result_valid,
    input  logic                         result_ready,
    input  logic                         flag_clr,
    output logic                         sat_flag,
    output logic                         overrun_flag
);

    state_t                       state;
    state_t                       next_state;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  acc_upd;
    logic signed [2*DATA_WIDTH-1:0] product;
    logic signed [ACC_WIDTH-1:0]  prod_ext;
    logic signed [OUT_WIDTH-1:0]  rs_value;
    logic                         rs_sat;
    logic                         fire;
    logic                         load;
    logic                         consume;

    assign fire     = north_valid & west_valid;
    assign load     = fire & acc_last;
    assign consume  = result_valid & result_ready;
    assign product  = in_north * in_west;
    assign prod_ext = ACC_WIDTH'(product);

    always_comb begin
        acc_upd = acc + prod_ext;
        if (acc_first || state == IDLE) begin
            acc_upd = prod_ext;
        end
    end

    always_comb begin
        next_state = state;
        if (fire) begin
            next_state = acc_last ? IDLE : ACC;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The result is taken from the post-update sum, so a last term is included.
    dct_round_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .FRAC_BITS (FRAC_BITS),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_round_sat (
        .acc   (acc_upd),
        .value (rs_value),
        .sat   (rs_sat)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc             <= '0;
            out_south       <= '0;
            out_east        <= '0;
            out_south_valid <= 1'b0;
            out_east_valid  <= 1'b0;
            result          <= '0;
            result_valid    <= 1'b0;
            sat_flag        <= 1'b0;
            overrun_flag    <= 1'b0;
        end else begin
            out_south       <= in_north;
            out_east        <= in_west;
            out_south_valid <= north_valid;
            out_east_valid  <= west_valid;

            if (fire) begin
                acc <= acc_upd;
            end

            if (load) begin
                result       <= rs_value;
                result_valid <= 1'b1;
            end else if (consume) begin
                result_valid <= 1'b0;
            end

            if (load && rs_sat) begin
                sat_flag <= 1'b1;
            end else if (flag_clr) begin
                sat_flag <= 1'b0;
            end

            if (load && result_valid && !result_ready) begin
                overrun_flag <= 1'b1;
            end else if (flag_clr) begin
                overrun_flag <= 1'b0;
            end
        end
    end

endmodule

// File: doc/dct_pe_mac.md
DCT_PE_MAC -- requirements
Module: dct_pe_mac

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, signed width of north/west operands.
REQ-002 SHALL have parameter ACC_WIDTH, default 40, signed accumulator width; legal range is ACC_WIDTH >= 2*DATA_WIDTH.
REQ-003 SHALL have parameter FRAC_BITS, default 14, fixed-point fraction bits removed from the result (Q1.14 DCT coefficients).
REQ-004 SHALL have parameter OUT_WIDTH, default 16, signed result width.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset, synchronous and active-low.
REQ-007 SHALL have in_north and in_west, both input, DATA_WIDTH, signed operands; north_valid and west_valid, both input, 1, operand qualifiers.
REQ-008 SHALL have acc_first and acc_last, both input, 1, qualified by fire; they mark the first and last term of a dot product.
REQ-009 SHALL have out_south and out_east, both output, DATA_WIDTH, the registered forwards of in_north and in_west.
REQ-010 SHALL have out_south_valid and out_east_valid, both output, 1, the registered forwards of the valids.
REQ-011 SHALL have result, output, OUT_WIDTH, signed; result_valid, output, 1; result_ready, input, 1.
REQ-012 SHALL have flag_clr, input, 1; sat_flag, output, 1, sticky; overrun_flag, output, 1, sticky.

Function
REQ-013 SHALL define fire = north_valid & west_valid; no accumulator update occurs without fire.
REQ-014 SHALL forward out_south/out_south_valid and out_east/out_east_valid with exactly 1-cycle latency every cycle, independent of fire or of result backpressure.
REQ-015 SHALL form product = in_north*in_west at full 2*DATA_WIDTH signed precision, sign-extended to ACC_WIDTH.
REQ-016 SHALL implement states IDLE (no open sum) and ACC (open sum).
REQ-017 SHALL, on fire with acc_first, or on fire in IDLE: load acc = product and go to ACC; any prior partial sum is discarded.
REQ-018 SHALL, on fire in ACC without acc_first: set acc = acc + product, wrapping modulo 2^ACC_WIDTH.
REQ-019 SHALL, on fire with acc_last, take the post-update acc value and go to IDLE; first and last together yield a single-term result.
REQ-020 SHALL form the final value as (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS (arithmetic shift, round half up); with FRAC_BITS = 0, no rounding is applied.
REQ-021 SHALL clamp the final value to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; when clamping occurs, sat_flag is set.
REQ-022 SHALL, in the cycle after fire with acc_last, present the result and assert result_valid.
REQ-023 SHALL hold result and result_valid stable until a cycle with result_valid & result_ready; result_valid falls in the cycle after that, unless a new load occurs.
REQ-024 SHALL, when a new load occurs while result_valid=1 and result_ready=0: overwrite result, keep result_valid=1, and set overrun_flag.
REQ-025 SHALL, when a load and a consume occur in the same cycle: load the new result, keep result_valid=1, and leave overrun_flag unchanged.
REQ-026 SHALL clear both sticky flags one cycle after flag_clr=1; if a set event occurs in the same cycle, set takes priority.

Reset
REQ-027 SHALL, on a clock edge with rst=0, clear acc, result, out_south and out_east to 0; clear all valids and flags to 0; and set state to IDLE.
REQ-028 SHALL discard any partial sum when reset occurs mid-accumulation; the first fire after reset behaves as a first term.

Structure
REQ-029 SHALL take parameter defaults and the state enum (IDLE, ACC) from shared package dct_pkg.
REQ-030 SHALL place the combinational rounding and saturation logic in sub-module dct_round_sat (parameters ACC_WIDTH, FRAC_BITS, OUT_WIDTH; outputs the value and a sat indication).

Verification
REQ-031 Dot product: 8 fires of north=16384 and west=100, first on term 1, last on term 8, result_ready=1 -> result=800, result_valid for 1 cycle, sat_flag=0.
REQ-032 Rounding: single-term fire with north=1 and west=8192 -> result=1; single-term fire with north=-1 and west=8192 -> result=0.
REQ-033 Saturation: 8 terms of north=-32768 and west=-32768 -> result=32767 and sat_flag=1; flag_clr -> sat_flag=0.
REQ-034 Backpressure: two single-term results (5 and 7, north=16384) with result_ready=0 -> result=7, overrun_flag=1; repeat with result_ready=1 in the second load cycle -> overrun_flag=0.
REQ-035 Forwarding and gaps: north_valid toggles each cycle with west_valid=1 -> out_south/out_east mirror the inputs 1 cycle later, and acc sums only the fire cycles.
REQ-036 Reset mid-sum: 3 terms accumulated, rst=0 for 1 cycle, then a 1-term sum of 16384 x 3 -> result=3, with all outputs 0 in the cycle after reset.
